// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares one multi-cycle main memory between the I-cache
// and D-cache miss handlers. One miss is serviced at a time. A dirty D-cache
// victim is written back word by word before the missing line is filled word
// by word. The owning cache gets a one-cycle done pulse when its line is in.

module cache_fill_arbiter #(
  parameter  int ADDR_W     = 16,
  parameter  int DATA_W     = 16,
  parameter  int LINE_WORDS = 4,
  localparam int OFF        = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache miss handler
  input  logic              i_ic_req,
  input  logic [ADDR_W-1:0] i_ic_addr,
  // D-cache miss handler
  input  logic              i_dc_req,
  input  logic [ADDR_W-1:0] i_dc_addr,
  input  logic              i_dc_dirty,
  input  logic [ADDR_W-1:0] i_dc_victim_addr,
  input  logic [DATA_W-1:0] i_dc_wb_data,
  // cache-side steering
  output logic [OFF-1:0]    o_wb_idx,
  output logic [OFF-1:0]    o_fill_idx,
  output logic [DATA_W-1:0] o_fill_data,
  output logic              o_ic_fill_we,
  output logic              o_dc_fill_we,
  output logic              o_ic_done,
  output logic              o_dc_done,
  // main memory port
  output logic              o_mem_en,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [OFF-1:0] CNT_ONE  = OFF'(1);
  localparam logic [OFF-1:0] CNT_LAST = OFF'(LINE_WORDS - 1);

  state_t                r_state;
  logic                  r_owner_d;
  logic [OFF-1:0]        r_cnt;
  logic [ADDR_W-1:OFF+1] r_miss_line;
  logic [ADDR_W-1:OFF+1] r_victim_line;
  logic                  r_mem_en;
  logic                  r_mem_wr;
  logic                  r_busy;

  logic                  w_fill_hs;
  logic                  w_unused_addr_bits;

  // Word offset and byte-select bits of the request addresses are not needed:
  // transfers always cover the whole line starting at word 0.
  assign w_unused_addr_bits = ^{i_ic_addr[OFF:0], i_dc_addr[OFF:0],
                                i_dc_victim_addr[OFF:0]};

  // Sequencer: grant (D before I), write back a dirty victim, fill, then done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_owner_d     <= 1'b0;
      r_cnt         <= '0;
      r_miss_line   <= '0;
      r_victim_line <= '0;
      r_mem_en      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_dc_req) begin
            r_owner_d     <= 1'b1;
            r_miss_line   <= i_dc_addr[ADDR_W-1:OFF+1];
            r_victim_line <= i_dc_victim_addr[ADDR_W-1:OFF+1];
            r_cnt         <= '0;
            r_mem_en      <= 1'b1;
            r_mem_wr      <= i_dc_dirty;
            r_busy        <= 1'b1;
            r_state       <= i_dc_dirty ? S_WB : S_FILL;
          end else if (i_ic_req) begin
            r_owner_d     <= 1'b0;
            r_miss_line   <= i_ic_addr[ADDR_W-1:OFF+1];
            r_cnt         <= '0;
            r_mem_en      <= 1'b1;
            r_mem_wr      <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_FILL;
          end
        end
        S_WB: begin
          if (i_mem_ack) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt    <= '0;
              r_mem_wr <= 1'b0;
              r_state  <= S_FILL;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        S_FILL: begin
          if (i_mem_ack) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
              r_mem_en <= 1'b0;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_mem_wr <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Memory address/data mux and per-cache fill/done steering from the state.
  always_comb begin
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    w_fill_hs    = 1'b0;
    o_ic_fill_we = 1'b0;
    o_dc_fill_we = 1'b0;
    o_ic_done    = 1'b0;
    o_dc_done    = 1'b0;
    case (r_state)
      S_WB: begin
        o_mem_addr  = {r_victim_line, r_cnt, 1'b0};
        o_mem_wdata = i_dc_wb_data;
      end
      S_FILL: begin
        o_mem_addr   = {r_miss_line, r_cnt, 1'b0};
        w_fill_hs    = i_mem_ack;
        o_ic_fill_we = w_fill_hs & ~r_owner_d;
        o_dc_fill_we = w_fill_hs & r_owner_d;
      end
      S_DONE: begin
        o_ic_done = ~r_owner_d;
        o_dc_done = r_owner_d;
      end
      default: begin
        o_mem_addr = '0;
      end
    endcase
  end

  assign o_mem_en    = r_mem_en;
  assign o_mem_wr    = r_mem_wr;
  assign o_busy      = r_busy;
  assign o_wb_idx    = r_cnt;
  assign o_fill_idx  = r_cnt;
  assign o_fill_data = i_mem_rdata;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: drives cache misses into cache_fill_arbiter against
// a memory model with programmable ack latency. Expected memory accesses are
// queued when a miss is issued and checked as each access is acked.

module tb_cache_fill_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int OFF        = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              icReq = 1'b0;
  logic [ADDR_W-1:0] icAddr = '0;
  logic              dcReq = 1'b0;
  logic [ADDR_W-1:0] dcAddr = '0;
  logic              dcDirty = 1'b0;
  logic [ADDR_W-1:0] dcVictimAddr = '0;
  logic [DATA_W-1:0] dcWbData;
  logic [OFF-1:0]    wbIdx;
  logic [OFF-1:0]    fillIdx;
  logic [DATA_W-1:0] fillData;
  logic              icFillWe;
  logic              dcFillWe;
  logic              icDone;
  logic              dcDone;
  logic              memEn;
  logic              memWr;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memAck = 1'b0;
  logic [DATA_W-1:0] memRdata = '0;
  logic              busy;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  idx;
    logic        isD;
  } access_t;

  typedef struct {
    logic        isD;
    logic [15:0] addr;
    logic        dirty;
    logic [15:0] victim;
    int          ackDelay;
    logic        tieAck;
    int          expSpan;
  } vector_t;

  access_t expQ[$];
  access_t monEntry;
  vector_t vec[6];

  int passChecks = 0;
  int totalChecks = 0;
  int cycleNo = 0;
  int ackDelay = 1;
  logic tieAck = 1'b0;
  int memCnt = 0;
  logic lastHs = 1'b0;
  int icDoneCount = 0;
  int dcDoneCount = 0;
  int icDoneCycle = 0;
  int dcDoneCycle = 0;
  int riseCycle = 0;
  int fillAckCount = 0;
  int strayCount = 0;
  int stableErr = 0;
  int reqCycle = 0;
  logic prevEn = 1'b0;
  logic prevHold = 1'b0;
  logic holdWr = 1'b0;
  logic [15:0] holdAddr = '0;
  logic [15:0] holdWdata = '0;

  cache_fill_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_ic_req(icReq),
    .i_ic_addr(icAddr),
    .i_dc_req(dcReq),
    .i_dc_addr(dcAddr),
    .i_dc_dirty(dcDirty),
    .i_dc_victim_addr(dcVictimAddr),
    .i_dc_wb_data(dcWbData),
    .o_wb_idx(wbIdx),
    .o_fill_idx(fillIdx),
    .o_fill_data(fillData),
    .o_ic_fill_we(icFillWe),
    .o_dc_fill_we(dcFillWe),
    .o_ic_done(icDone),
    .o_dc_done(dcDone),
    .o_mem_en(memEn),
    .o_mem_wr(memWr),
    .o_mem_addr(memAddr),
    .o_mem_wdata(memWdata),
    .i_mem_ack(memAck),
    .i_mem_rdata(memRdata),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // The D-cache victim line reads back a recognisable pattern per word.
  assign dcWbData = 16'hB000 | 16'(wbIdx);

  function automatic logic [15:0] rdataOf(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) passChecks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Memory model: acks in the ackDelay-th cycle of each access, or always when tied.
  always @(posedge clk) begin
    #1;
    if (lastHs) memCnt = 0;
    if (rst_n && memEn) memCnt++;
    else memCnt = 0;
    memAck   = tieAck || (memEn && memCnt >= ackDelay);
    memRdata = rdataOf(memAddr);
    lastHs   = memEn && memAck;
  end

  // Monitor: scoreboard every acked access, track done pulses and handshake stability.
  always @(negedge clk) begin
    if (icDone) begin icDoneCount++; icDoneCycle = cycleNo; end
    if (dcDone) begin dcDoneCount++; dcDoneCycle = cycleNo; end
    if (rst_n) begin
      if (prevHold) begin
        if (!memEn || memWr !== holdWr || memAddr !== holdAddr || memWdata !== holdWdata)
          stableErr++;
      end
      if (memEn && memAck) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedAccess", 32'(expQ.size()), 32'd1);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("memAccess", 32'({memWr, memAddr}), 32'({monEntry.wr, monEntry.addr}));
          if (monEntry.wr) begin
            checkOutput("wbWord", 32'({wbIdx, memWdata}), 32'({monEntry.idx, monEntry.wdata}));
            checkOutput("wbNoFillWe", 32'({icFillWe, dcFillWe}), 32'd0);
          end else begin
            checkOutput("fillWe", 32'({icFillWe, dcFillWe, fillIdx}),
                        32'({~monEntry.isD, monEntry.isD, monEntry.idx}));
            checkOutput("fillData", 32'(fillData), 32'(rdataOf(monEntry.addr)));
            fillAckCount++;
          end
        end
      end else if (icFillWe || dcFillWe) begin
        strayCount++;
      end
      if (memEn && !prevEn) riseCycle = cycleNo;
      prevEn    = memEn;
      prevHold  = memEn && !memAck;
      holdWr    = memWr;
      holdAddr  = memAddr;
      holdWdata = memWdata;
    end else begin
      prevEn   = 1'b0;
      prevHold = 1'b0;
    end
  end

  task automatic clearCounters();
    icDoneCount  = 0;
    dcDoneCount  = 0;
    fillAckCount = 0;
    strayCount   = 0;
    stableErr    = 0;
  endtask

  // Queue the accesses one miss must produce: optional write-back, then fill.
  task automatic pushLine(input logic isD, input logic dirty, input logic [15:0] addr,
                          input logic [15:0] victim);
    access_t a;
    if (dirty) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        a.wr    = 1'b1;
        a.addr  = (victim & 16'hFFF8) + 16'(2 * i);
        a.wdata = 16'hB000 | 16'(i);
        a.idx   = 2'(i);
        a.isD   = 1'b1;
        expQ.push_back(a);
      end
    end
    for (int i = 0; i < LINE_WORDS; i++) begin
      a.wr    = 1'b0;
      a.addr  = (addr & 16'hFFF8) + 16'(2 * i);
      a.wdata = 16'h0000;
      a.idx   = 2'(i);
      a.isD   = isD;
      expQ.push_back(a);
    end
  endtask

  task automatic waitDone(input bit forD, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      tick();
      if ((forD ? dcDoneCount : icDoneCount) != 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput(forD ? "dcDoneTimeout" : "icDoneTimeout", 32'd0, 32'd1);
  endtask

  // Issue one miss from the table, wait for its done, then check the aftermath.
  task automatic applyStimulus(input vector_t v);
    bit ok;
    int doneCycle;
    clearCounters();
    ackDelay = v.ackDelay;
    tieAck   = v.tieAck;
    pushLine(v.isD, v.isD && v.dirty, v.addr, v.victim);
    if (v.isD) begin
      dcAddr       = v.addr;
      dcDirty      = v.dirty;
      dcVictimAddr = v.victim;
      dcReq        = 1'b1;
    end else begin
      icAddr = v.addr;
      icReq  = 1'b1;
    end
    reqCycle = cycleNo;
    tick();
    checkOutput("grantLatency", 32'({busy, memEn}), 32'd3);
    waitDone(v.isD, 500, ok);
    dcReq   = 1'b0;
    icReq   = 1'b0;
    dcDirty = 1'b0;
    checkOutput("doneSpan", 32'((v.isD ? dcDoneCycle : icDoneCycle) - reqCycle + 1),
                32'(v.expSpan));
    doneCycle = v.isD ? 32'h0001 : 32'h0100;
    checkOutput("doneCounts", 32'({icDoneCount[7:0], dcDoneCount[7:0]}), 32'(doneCycle));
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("strayWe", 32'(strayCount), 32'd0);
    checkOutput("stable", 32'(stableErr), 32'd0);
    tick();
    checkOutput("busyIdle", 32'(busy), 32'd0);
    tieAck = 1'b0;
  endtask

  // Both requests pending: D finishes first, I gets memory two cycles after dc_done.
  task automatic finishBoth();
    bit ok;
    waitDone(1'b1, 500, ok);
    dcReq   = 1'b0;
    dcDirty = 1'b0;
    waitDone(1'b0, 500, ok);
    icReq = 1'b0;
    checkOutput("bothDoneCounts", 32'({icDoneCount[7:0], dcDoneCount[7:0]}), 32'h0101);
    checkOutput("gapAfterDcDone", 32'(riseCycle - dcDoneCycle), 32'd2);
    checkOutput("bothQueueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("bothStrayWe", 32'(strayCount), 32'd0);
    checkOutput("bothStable", 32'(stableErr), 32'd0);
    tick();
    checkOutput("bothBusyIdle", 32'(busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Ctrl"}, 32'({memEn, memWr, icFillWe, dcFillWe, icDone, dcDone, busy}), 32'd0);
    checkOutput({tag, "AddrData"}, {memAddr, memWdata}, 32'd0);
    checkOutput({tag, "Idx"}, 32'({wbIdx, fillIdx}), 32'd0);
  endtask

  initial begin
    bit ok;
    vec[0] = '{isD: 1'b0, addr: 16'h0124, dirty: 1'b0, victim: 16'h0000, ackDelay: 4, tieAck: 1'b0, expSpan: 18};
    vec[1] = '{isD: 1'b1, addr: 16'h2008, dirty: 1'b1, victim: 16'h1000, ackDelay: 3, tieAck: 1'b0, expSpan: 26};
    vec[2] = '{isD: 1'b0, addr: 16'hFFFF, dirty: 1'b0, victim: 16'h0000, ackDelay: 1, tieAck: 1'b0, expSpan: 6};
    vec[3] = '{isD: 1'b0, addr: 16'h5A5A, dirty: 1'b0, victim: 16'h0000, ackDelay: 1, tieAck: 1'b1, expSpan: 6};
    vec[4] = '{isD: 1'b1, addr: 16'h8001, dirty: 1'b1, victim: 16'h7FFE, ackDelay: 1, tieAck: 1'b1, expSpan: 10};
    vec[5] = '{isD: 1'b1, addr: 16'h1234, dirty: 1'b0, victim: 16'hABCD, ackDelay: 2, tieAck: 1'b0, expSpan: 10};

    // Reset held with both requests pending, then D must win after release.
    icReq        = 1'b1;
    icAddr       = 16'h0012;
    dcReq        = 1'b1;
    dcAddr       = 16'h0026;
    dcDirty      = 1'b1;
    dcVictimAddr = 16'h0040;
    repeat (3) tick();
    checkResetOutputs("rstHold");
    clearCounters();
    pushLine(1'b1, 1'b1, dcAddr, dcVictimAddr);
    pushLine(1'b0, 1'b0, icAddr, 16'h0000);
    rst_n = 1'b1;
    tick();
    checkOutput("grantD2ndCycle", 32'({memEn, memWr, memAddr}), 32'({1'b1, 1'b1, 16'h0040}));
    finishBoth();

    for (int i = 0; i < 6; i++) applyStimulus(vec[i]);

    // Simultaneous requests with distinct lines.
    clearCounters();
    ackDelay = 2;
    icAddr   = 16'h3000;
    dcAddr   = 16'h4000;
    dcDirty  = 1'b0;
    pushLine(1'b1, 1'b0, dcAddr, 16'h0000);
    pushLine(1'b0, 1'b0, icAddr, 16'h0000);
    icReq = 1'b1;
    dcReq = 1'b1;
    finishBoth();

    // Reset in the middle of a fill after two words are in.
    clearCounters();
    ackDelay = 2;
    icAddr   = 16'h0A46;
    pushLine(1'b0, 1'b0, icAddr, 16'h0000);
    icReq = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (fillAckCount >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("twoAcksTimeout", 32'd0, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rstAbort");
    repeat (3) tick();
    checkOutput("noDoneAfterAbort", 32'(icDoneCount + dcDoneCount), 32'd0);
    expQ.delete();
    pushLine(1'b0, 1'b0, icAddr, 16'h0000);
    rst_n    = 1'b1;
    reqCycle = cycleNo;
    waitDone(1'b0, 200, ok);
    icReq = 1'b0;
    checkOutput("restartSpan", 32'(icDoneCycle - reqCycle + 1), 32'd10);
    checkOutput("restartDoneCounts", 32'({icDoneCount[7:0], dcDoneCount[7:0]}), 32'h0100);
    checkOutput("restartQueueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("restartStrayWe", 32'(strayCount), 32'd0);
    tick();

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
